// File: rtl/display_timebase.sv
// display_timebase
// Free-running timebase (slow tick + scan tick) and a registered 4-digit
// multiplexed 7-segment decoder driving active-low segment/anode pins.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset, synchronous release
//   seg_number  hex value shown on the selected digit
//   an_number   digit index, 0 = leftmost (an[3]) .. 3 = rightmost (an[0])
//   btnU        lights the decimal point of the selected digit when high
//   tick_1hz    one-clk pulse every CLK_HZ/SLOW_HZ cycles
//   tick_500hz  one-clk pulse every CLK_HZ/SCAN_HZ cycles
//   seg         active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   an          active-low one-hot anode select
module display_timebase #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SLOW_HZ = 1,
  parameter int unsigned SCAN_HZ = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] seg_number,
  input  logic [1:0] an_number,
  input  logic       btnU,
  output logic       tick_1hz,
  output logic       tick_500hz,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int unsigned DIV1 = CLK_HZ / SLOW_HZ;
  localparam int unsigned DIV5 = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW1  = (DIV1 > 1) ? $clog2(DIV1) : 1;
  localparam int unsigned CW5  = (DIV5 > 1) ? $clog2(DIV5) : 1;

  logic [CW1-1:0] cnt1;
  logic [CW5-1:0] cnt5;
  logic           wrap1_c;
  logic           wrap5_c;
  logic [6:0]     hex_c;
  logic [3:0]     an_c;

  assign wrap1_c = (cnt1 == CW1'(DIV1 - 1));
  assign wrap5_c = (cnt5 == CW5'(DIV5 - 1));

  // Slow tick: pulse registered on the edge where the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1     <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= wrap1_c;
      cnt1     <= wrap1_c ? '0 : cnt1 + CW1'(1);
    end
  end

  // Scan tick: same structure as the slow tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt5       <= '0;
      tick_500hz <= 1'b0;
    end else begin
      tick_500hz <= wrap5_c;
      cnt5       <= wrap5_c ? '0 : cnt5 + CW5'(1);
    end
  end

  // Active-low hex to segment map, seg[6:0] = g..a.
  always_comb begin
    hex_c = 7'h7F;
    unique case (seg_number)
      4'h0: hex_c = 7'h40;
      4'h1: hex_c = 7'h79;
      4'h2: hex_c = 7'h24;
      4'h3: hex_c = 7'h30;
      4'h4: hex_c = 7'h19;
      4'h5: hex_c = 7'h12;
      4'h6: hex_c = 7'h02;
      4'h7: hex_c = 7'h78;
      4'h8: hex_c = 7'h00;
      4'h9: hex_c = 7'h10;
      4'hA: hex_c = 7'h08;
      4'hB: hex_c = 7'h03;
      4'hC: hex_c = 7'h46;
      4'hD: hex_c = 7'h21;
      4'hE: hex_c = 7'h06;
      4'hF: hex_c = 7'h0E;
    endcase
  end

  // Digit index 0 is the leftmost anode (an[3]).
  always_comb begin
    an_c = 4'hF;
    unique case (an_number)
      2'd0: an_c = 4'b0111;
      2'd1: an_c = 4'b1011;
      2'd2: an_c = 4'b1101;
      2'd3: an_c = 4'b1110;
    endcase
  end

  // Output register; blank display while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= {~btnU, hex_c};
      an  <= an_c;
    end
  end

endmodule

// File: tb/tb_display_timebase.sv
module tb_display_timebase;

  logic       clk;
  logic       rst_n;
  logic [3:0] seg_number;
  logic [1:0] an_number;
  logic       btnU;
  logic       tick_1hz;
  logic       tick_500hz;
  logic [7:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_seg [16];
  logic [3:0] exp_an  [4];

  display_timebase #(
    .CLK_HZ (1000),
    .SLOW_HZ(1),
    .SCAN_HZ(500)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_number(seg_number),
    .an_number (an_number),
    .btnU      (btnU),
    .tick_1hz  (tick_1hz),
    .tick_500hz(tick_500hz),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi1_cnt;
    int hi5_cnt;
    int alt_bad;
    int first_hi;
    int pos [$];
    logic prev5;

    exp_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    exp_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Reset with random inputs.
    rst_n      = 1'b0;
    seg_number = 4'($urandom);
    an_number  = 2'($urandom);
    btnU       = 1'($urandom);
    repeat (3) step();
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_an", 32'(an), 32'hF);
    check("rst_tick1", 32'(tick_1hz), 32'd0);
    check("rst_tick5", 32'(tick_500hz), 32'd0);

    // Release between edges; edge numbering starts at the next posedge.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("edge1_tick5", 32'(tick_500hz), 32'd0);
    step();
    check("edge2_tick5", 32'(tick_500hz), 32'd1);
    repeat (997) step();
    check("edge999_tick1", 32'(tick_1hz), 32'd0);
    step();
    check("edge1000_tick1", 32'(tick_1hz), 32'd1);

    // Periodicity over edges 1001..6000.
    hi1_cnt = 0;
    hi5_cnt = 0;
    alt_bad = 0;
    prev5   = tick_500hz;
    for (int e = 1001; e <= 6000; e++) begin
      step();
      if (tick_1hz) begin
        hi1_cnt++;
        pos.push_back(e);
      end
      if (tick_500hz) hi5_cnt++;
      if (tick_500hz == prev5) alt_bad++;
      prev5 = tick_500hz;
    end
    check("period_tick1_count", 32'(hi1_cnt), 32'd5);
    for (int i = 0; i < pos.size(); i++)
      check("period_tick1_pos", 32'(pos[i]), 32'(2000 + 1000 * i));
    check("period_tick5_count", 32'(hi5_cnt), 32'd2500);
    check("period_tick5_alternate", 32'(alt_bad), 32'd0);

    // Decode sweep on the rightmost digit, dp off.
    an_number = 2'd3;
    btnU      = 1'b0;
    for (int v = 0; v < 16; v++) begin
      seg_number = 4'(v);
      #1;
      if (v > 0) check("sweep_hold", 32'(seg), 32'(exp_seg[v-1]));
      step();
      check("sweep_seg", 32'(seg), 32'(exp_seg[v]));
      check("sweep_an", 32'(an), 32'(4'b1110));
    end

    // Digit select with decimal point lit.
    seg_number = 4'h8;
    btnU       = 1'b1;
    for (int d = 0; d < 4; d++) begin
      an_number = 2'(d);
      step();
      check("digit_an", 32'(an), 32'(exp_an[d]));
      check("digit_seg", 32'(seg), 32'h00);
    end

    // Async reset mid-run at counter = 500.
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'hFF);
    check("async_an", 32'(an), 32'hF);
    check("async_tick1", 32'(tick_1hz), 32'd0);
    check("async_tick5", 32'(tick_500hz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    first_hi = 0;
    for (int e = 1; e <= 1100; e++) begin
      step();
      if (tick_1hz && first_hi == 0) first_hi = e;
    end
    check("async_first_tick1", 32'(first_hi), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
